// File: rtl/pc_gen_ras.sv
// Fetch-PC generator for the IF stage with an integrated return address stack.
// The RAS pointer/count checkpoint rides with each fetched instruction and is restored on mispredict.
module pc_gen_ras #(
    parameter int unsigned      XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int unsigned      RAS_DEPTH  = 8,
    parameter int unsigned      INST_BYTES = 4,
    localparam int unsigned     P          = $clog2(RAS_DEPTH),
    localparam int unsigned     CW         = 2 * P + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            wfi_hold,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic [CW-1:0]   redirect_ckpt,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_pc,
    input  logic            call_if,
    input  logic            ret_if,
    output logic [XLEN-1:0] pc,
    output logic [CW-1:0]   ras_ckpt,
    output logic [P:0]      ras_count,
    output logic            ras_underflow
);

    localparam logic [P:0]      DEPTH_C = (P+1)'(RAS_DEPTH);
    localparam logic [XLEN-1:0] LSB_C   = XLEN'(1);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [P-1:0]    ptr_q, ptr_d;
    logic [P:0]      cnt_q, cnt_d;
    logic            uf_q, uf_d;
    logic [XLEN-1:0] stack_q [RAS_DEPTH];

    logic            advance;
    logic            ras_hit;
    logic [XLEN-1:0] pc_inc;
    logic            wr_en;
    logic [P-1:0]    wr_idx;

    // Loaded targets are halfword aligned: bit 0 is always dropped.
    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] a);
        return a & ~LSB_C;
    endfunction

    assign advance = !trap_valid && !redirect_valid && !stall && !wfi_hold;
    assign ras_hit = ret_if && (cnt_q != '0);
    assign pc_inc  = pc_q + XLEN'(INST_BYTES);

    // Next-PC selection and RAS pointer/count update.
    always_comb begin
        pc_d   = pc_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        uf_d   = 1'b0;
        wr_en  = 1'b0;
        wr_idx = ptr_q;

        if (trap_valid)                pc_d = align(trap_pc);
        else if (redirect_valid)       pc_d = align(redirect_pc);
        else if (stall || wfi_hold)    pc_d = pc_q;
        else if (ras_hit)              pc_d = align(stack_q[ptr_q]);
        else if (pred_taken)           pc_d = align(pred_pc);
        else                           pc_d = pc_inc;

        if (redirect_valid) begin
            {ptr_d, cnt_d} = redirect_ckpt;
        end

        if (advance) begin
            uf_d = ret_if && !ras_hit;
            if (call_if && ras_hit) begin
                // Coroutine swap: replace the top entry in place.
                wr_en = 1'b1;
            end else if (call_if) begin
                ptr_d  = ptr_q + P'(1);
                wr_idx = ptr_q + P'(1);
                wr_en  = 1'b1;
                cnt_d  = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + (P+1)'(1);
            end else if (ras_hit) begin
                ptr_d = ptr_q - P'(1);
                cnt_d = cnt_q - (P+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            uf_q  <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            uf_q  <= uf_d;
            if (wr_en) stack_q[wr_idx] <= pc_inc;
        end
    end

    assign pc            = pc_q;
    assign ras_ckpt      = {ptr_q, cnt_q};
    assign ras_count     = cnt_q;
    assign ras_underflow = uf_q;

endmodule
